// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: squashes the committing instruction on a trap, interrupt or mret.
// It then writes the trap CSRs and offers a valid/ready PC redirect to fetch.
module trap_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit_valid,
  input  logic [63:0] commit_pc,
  input  logic [31:0] commit_inst,
  input  logic        is_ecall,
  input  logic        is_ebreak,
  input  logic        is_mret,
  input  logic        is_illegal,
  input  logic        timer_irq,
  input  logic [63:0] mstatus_rd_data,
  input  logic [63:0] mie_rd_data,
  input  logic [63:0] mtvec_rd_data,
  input  logic [63:0] mepc_rd_data,
  output logic        excp_enter,
  output logic        excp_exit,
  output logic [63:0] mstatus_wr_data,
  output logic [63:0] mepc_wr_data,
  output logic [63:0] mcause_wr_data,
  output logic [63:0] mtval_wr_data,
  output logic        flush,
  output logic        stall,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  input  logic        redirect_ready
);

  typedef enum logic [1:0] {IDLE, ENTER, EXIT, REDIRECT} state_t;

  state_t      state, state_nxt;
  logic [63:0] epc_q, cause_q, tval_q, target_q;
  logic [63:0] cause_nxt, tval_nxt, target_nxt, base;
  logic        irq, req, accept;

  // Only the MTIE bit of mie is consulted.
  logic unused_mie_bits;
  assign unused_mie_bits = ^{mie_rd_data[63:8], mie_rd_data[6:0]};

  assign irq    = timer_irq & mie_rd_data[7] & mstatus_rd_data[3];
  assign req    = irq | is_illegal | is_ebreak | is_ecall | is_mret;
  assign accept = (state == IDLE) & commit_valid & req & ~rst;
  assign base   = {mtvec_rd_data[63:2], 2'b00};

  always_comb begin
    cause_nxt = 64'd0;
    tval_nxt  = 64'd0;
    if (irq) begin
      cause_nxt = 64'h8000_0000_0000_0007;
    end else if (is_illegal) begin
      cause_nxt = 64'd2;
      tval_nxt  = {32'd0, commit_inst};
    end else if (is_ebreak) begin
      cause_nxt = 64'd3;
      tval_nxt  = commit_pc;
    end else if (is_ecall) begin
      cause_nxt = 64'd11;
    end
  end

  always_comb begin
    state_nxt       = state;
    target_nxt      = target_q;
    flush           = 1'b0;
    stall           = 1'b0;
    excp_enter      = 1'b0;
    excp_exit       = 1'b0;
    mstatus_wr_data = 64'd0;
    mepc_wr_data    = 64'd0;
    mcause_wr_data  = 64'd0;
    mtval_wr_data   = 64'd0;
    redirect_valid  = 1'b0;
    redirect_pc     = 64'd0;
    case (state)
      IDLE: begin
        if (accept) begin
          flush = 1'b1;
          // mret is lowest priority, so it only wins when nothing else is pending.
          state_nxt = (irq | is_illegal | is_ebreak | is_ecall) ? ENTER : EXIT;
        end
      end
      ENTER: begin
        stall               = 1'b1;
        excp_enter          = 1'b1;
        mepc_wr_data        = epc_q;
        mcause_wr_data      = cause_q;
        mtval_wr_data       = tval_q;
        mstatus_wr_data     = mstatus_rd_data;
        mstatus_wr_data[7]  = mstatus_rd_data[3];
        mstatus_wr_data[3]  = 1'b0;
        mstatus_wr_data[12:11] = 2'b11;
        if (mtvec_rd_data[1:0] == 2'b01 && cause_q[63])
          target_nxt = base + {56'd0, cause_q[5:0], 2'b00};
        else
          target_nxt = base;
        state_nxt = REDIRECT;
      end
      EXIT: begin
        stall               = 1'b1;
        excp_exit           = 1'b1;
        mstatus_wr_data     = mstatus_rd_data;
        mstatus_wr_data[3]  = mstatus_rd_data[7];
        mstatus_wr_data[7]  = 1'b1;
        mstatus_wr_data[12:11] = 2'b11;
        target_nxt          = mepc_rd_data;
        state_nxt           = REDIRECT;
      end
      REDIRECT: begin
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = target_q;
        if (redirect_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      epc_q    <= 64'd0;
      cause_q  <= 64'd0;
      tval_q   <= 64'd0;
      target_q <= 64'd0;
    end else begin
      state    <= state_nxt;
      target_q <= target_nxt;
      if (accept) begin
        epc_q   <= commit_pc;
        cause_q <= cause_nxt;
        tval_q  <= tval_nxt;
      end
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed table-driven bench for trap_ctrl plus hand sequences for backpressure, masking and reset.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        commit_valid;
  logic [63:0] commit_pc;
  logic [31:0] commit_inst;
  logic        is_ecall, is_ebreak, is_mret, is_illegal, timer_irq;
  logic [63:0] mstatus_rd_data, mie_rd_data, mtvec_rd_data, mepc_rd_data;
  logic        excp_enter, excp_exit, flush, stall, redirect_valid, redirect_ready;
  logic [63:0] mstatus_wr_data, mepc_wr_data, mcause_wr_data, mtval_wr_data, redirect_pc;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  trap_ctrl dut (
    .clk(clk), .rst(rst),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_inst(commit_inst),
    .is_ecall(is_ecall), .is_ebreak(is_ebreak), .is_mret(is_mret), .is_illegal(is_illegal),
    .timer_irq(timer_irq),
    .mstatus_rd_data(mstatus_rd_data), .mie_rd_data(mie_rd_data),
    .mtvec_rd_data(mtvec_rd_data), .mepc_rd_data(mepc_rd_data),
    .excp_enter(excp_enter), .excp_exit(excp_exit),
    .mstatus_wr_data(mstatus_wr_data), .mepc_wr_data(mepc_wr_data),
    .mcause_wr_data(mcause_wr_data), .mtval_wr_data(mtval_wr_data),
    .flush(flush), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .redirect_ready(redirect_ready)
  );

  typedef struct {
    string       name;
    logic [63:0] pc;
    logic [31:0] inst;
    logic        ecall, ebreak, mret, illegal, irq;
    logic [63:0] mstatus, mie, mtvec, mepc;
    logic        exp_exit;
    logic [63:0] exp_mepc, exp_cause, exp_tval, exp_mstatus, exp_target;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    commit_valid = 0; commit_pc = 0; commit_inst = 0;
    is_ecall = 0; is_ebreak = 0; is_mret = 0; is_illegal = 0; timer_irq = 0;
    redirect_ready = 0;
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    commit_valid = 1; commit_pc = v.pc; commit_inst = v.inst;
    is_ecall = v.ecall; is_ebreak = v.ebreak; is_mret = v.mret; is_illegal = v.illegal;
    timer_irq = v.irq; mstatus_rd_data = v.mstatus; mie_rd_data = v.mie;
    mtvec_rd_data = v.mtvec; mepc_rd_data = v.mepc;
    #1;
    chk({v.name, " T flush"}, 64'(flush), 64'd1);
    chk({v.name, " T stall"}, 64'(stall), 64'd0);
    @(negedge clk);
    commit_valid = 0; timer_irq = 0;
    #1;
    chk({v.name, " T+1 enter"}, 64'(excp_enter), 64'(!v.exp_exit));
    chk({v.name, " T+1 exit"}, 64'(excp_exit), 64'(v.exp_exit));
    chk({v.name, " T+1 stall"}, 64'(stall), 64'd1);
    chk({v.name, " T+1 mstatus_wr"}, mstatus_wr_data, v.exp_mstatus);
    if (!v.exp_exit) begin
      chk({v.name, " T+1 mepc_wr"}, mepc_wr_data, v.exp_mepc);
      chk({v.name, " T+1 mcause_wr"}, mcause_wr_data, v.exp_cause);
      chk({v.name, " T+1 mtval_wr"}, mtval_wr_data, v.exp_tval);
    end
    @(negedge clk);
    redirect_ready = 1;
    #1;
    chk({v.name, " T+2 rvalid"}, 64'(redirect_valid), 64'd1);
    chk({v.name, " T+2 rpc"}, redirect_pc, v.exp_target);
    chk({v.name, " T+2 strobes"}, 64'({excp_enter, excp_exit}), 64'd0);
    chk({v.name, " T+2 mstatus_wr zero"}, mstatus_wr_data, 64'd0);
    @(negedge clk);
    redirect_ready = 0;
    #1;
    chk({v.name, " T+3 idle stall"}, 64'(stall), 64'd0);
    chk({v.name, " T+3 rvalid"}, 64'(redirect_valid), 64'd0);
  endtask

  initial begin
    vecs[0] = '{"ecall", 64'h8000_0100, 32'h0, 1,0,0,0,0, 64'h8, 64'h0, 64'h8000_1000, 64'h0,
                0, 64'h8000_0100, 64'd11, 64'd0, 64'h1880, 64'h8000_1000};
    vecs[1] = '{"vec_irq", 64'h8000_0200, 32'h0, 1,0,0,0,1, 64'h8, 64'h80, 64'h8000_1001, 64'h0,
                0, 64'h8000_0200, 64'h8000_0000_0000_0007, 64'd0, 64'h1880, 64'h8000_101C};
    vecs[2] = '{"mret", 64'h8000_0900, 32'h0, 0,0,1,0,0, 64'h1880, 64'h0, 64'h8000_1000, 64'h8000_0104,
                1, 64'h0, 64'h0, 64'h0, 64'h1888, 64'h8000_0104};
    vecs[3] = '{"illegal", 64'h8000_0300, 32'hFFFF_FFFF, 0,0,0,1,0, 64'h8, 64'h0, 64'h8000_1001, 64'h0,
                0, 64'h8000_0300, 64'd2, 64'h0000_0000_FFFF_FFFF, 64'h1880, 64'h8000_1000};
    vecs[4] = '{"ebreak_mode3", 64'h8000_0400, 32'h0, 0,1,0,0,0, 64'h0, 64'h0, 64'h8000_2003, 64'h0,
                0, 64'h8000_0400, 64'd3, 64'h8000_0400, 64'h1800, 64'h8000_2000};
    vecs[5] = '{"prio_illegal", 64'h8000_0500, 32'h1234_5678, 1,1,1,1,0, 64'h88, 64'h0, 64'h8000_1000, 64'h0,
                0, 64'h8000_0500, 64'd2, 64'h1234_5678, 64'h1880, 64'h8000_1000};
    vecs[6] = '{"irq_mode2", 64'h8000_0600, 32'h0, 0,0,0,0,1, 64'h8, 64'h80, 64'h8000_3002, 64'h0,
                0, 64'h8000_0600, 64'h8000_0000_0000_0007, 64'd0, 64'h1880, 64'h8000_3000};

    idle_inputs();
    mstatus_rd_data = 0; mie_rd_data = 0; mtvec_rd_data = 0; mepc_rd_data = 0;
    rst = 1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset outputs", 64'({excp_enter, excp_exit, flush, stall, redirect_valid}), 64'd0);
    chk("reset rpc", redirect_pc, 64'd0);
    chk("reset mstatus_wr", mstatus_wr_data, 64'd0);
    chk("reset mepc_wr", mepc_wr_data, 64'd0);
    @(negedge clk);
    rst = 0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Backpressure: target held for 3 cycles, second ecall ignored.
    @(negedge clk);
    mstatus_rd_data = 64'h8; mtvec_rd_data = 64'h8000_4000; mie_rd_data = 0;
    commit_valid = 1; is_ecall = 1; commit_pc = 64'h8000_0700;
    @(negedge clk);
    #1 chk("bp enter", 64'(excp_enter), 64'd1);
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp rvalid held", 64'(redirect_valid), 64'd1);
      chk("bp rpc held", redirect_pc, 64'h8000_4000);
      chk("bp stall", 64'(stall), 64'd1);
      chk("bp flush ignored", 64'(flush), 64'd0);
      @(negedge clk);
    end
    redirect_ready = 1;
    #1;
    chk("bp handshake stall", 64'(stall), 64'd1);
    chk("bp handshake no accept", 64'(flush), 64'd0);
    @(negedge clk);
    redirect_ready = 0; commit_valid = 0; is_ecall = 0;
    #1;
    chk("bp idle stall", 64'(stall), 64'd0);
    chk("bp idle no enter", 64'(excp_enter), 64'd0);

    // Masked interrupt with normal commit: no trap.
    @(negedge clk);
    mstatus_rd_data = 64'h0; mie_rd_data = 64'h80; timer_irq = 1; commit_valid = 1;
    #1 chk("masked irq flush", 64'(flush), 64'd0);
    @(negedge clk);
    #1 chk("masked irq stall", 64'(stall), 64'd0);
    chk("masked irq enter", 64'(excp_enter), 64'd0);
    timer_irq = 0;
    // Flags without commit_valid are ignored.
    commit_valid = 0; is_ecall = 1; mstatus_rd_data = 64'h8;
    #1 chk("invalid ecall flush", 64'(flush), 64'd0);
    @(negedge clk);
    #1 chk("invalid ecall stall", 64'(stall), 64'd0);
    is_ecall = 0;

    // Reset while redirect is presented.
    @(negedge clk);
    commit_valid = 1; is_ecall = 1; mtvec_rd_data = 64'h8000_5000;
    @(negedge clk);
    commit_valid = 0; is_ecall = 0;
    @(negedge clk);
    #1 chk("rst pre rvalid", 64'(redirect_valid), 64'd1);
    rst = 1;
    @(negedge clk);
    #1;
    chk("rst rvalid", 64'(redirect_valid), 64'd0);
    chk("rst stall", 64'(stall), 64'd0);
    chk("rst rpc", redirect_pc, 64'd0);
    rst = 0;
    redirect_ready = 1;
    @(negedge clk);
    #1 chk("rst stays idle", 64'(stall), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
